// File: rtl/sys_array_seq_pkg.sv
// Shared types and width helpers for the run sequencer.
package sys_array_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    SCAN,
    DONE,
    ERR
  } state_t;

  // Bits needed for a counter running 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DWELL_DEF   = 25_000_000;
  localparam int TIMEOUT_DEF = 1_000_000;
  localparam int DWELL_W     = cnt_w(DWELL_DEF);
  localparam int WDOG_W      = cnt_w(TIMEOUT_DEF);

endpackage

// File: rtl/sys_array_seq_rise.sv
// One-bit registered rising-edge detector.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev;

  // Remember the previous sample of d.
  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/sys_array_seq.sv
// Run sequencer in front of sys_array_wrapper: load/start pulses, ready
// watchdog, then a timed row/col scan of every result element.
//
// state | meaning
// IDLE  | waiting for a start rise
// LOAD  | load_params pulse
// START | start_comp pulse, clear armed/watchdog
// WAIT  | wait for ready (after seeing it low) under watchdog
// SCAN  | step row/col, DWELL cycles per element
// DONE  | row/col follow sel_row/sel_col
// ERR   | watchdog expired, row/col hold
module sys_array_seq
  import sys_array_seq_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int ROW_W   = 4,
  parameter int COL_W   = 4,
  parameter int DWELL   = DWELL_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             ready,
  input  logic [ROW_W-1:0] sel_row,
  input  logic [COL_W-1:0] sel_col,
  output logic             load_params,
  output logic             start_comp,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int DW_W = cnt_w(DWELL);
  localparam int WD_W = cnt_w(TIMEOUT);

  logic             start_rise;
  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_d;
  logic [COL_W-1:0] col_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             armed_q, armed_d;

  rise_detect u_start_rise (
    .clk   (clk),
    .reset (reset),
    .d     (start),
    .rise  (start_rise)
  );

  // Next-state and counter logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    row_d   = row;
    col_d   = col;
    dwell_d = dwell_q;
    wdog_d  = wdog_q;
    armed_d = armed_q;
    if (abort) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      dwell_d = '0;
      wdog_d  = '0;
      armed_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (start_rise) state_d = LOAD;
        LOAD:  state_d = START;
        START: begin
          armed_d = 1'b0;
          wdog_d  = '0;
          state_d = WAIT;
        end
        WAIT: begin
          // A ready left high from an earlier run only counts once it has
          // been seen low in this run.
          if (armed_q && ready) begin
            state_d = SCAN;
            row_d   = '0;
            col_d   = '0;
            dwell_d = '0;
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            state_d = ERR;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
            if (!ready) armed_d = 1'b1;
          end
        end
        SCAN: begin
          if (dwell_q == DW_W'(DWELL - 1)) begin
            dwell_d = '0;
            if (col == COL_W'(COLS - 1)) begin
              if (row == ROW_W'(ROWS - 1)) begin
                state_d = DONE;
              end else begin
                col_d = '0;
                row_d = row + ROW_W'(1);
              end
            end else begin
              col_d = col + COL_W'(1);
            end
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
        DONE: begin
          row_d = sel_row;
          col_d = sel_col;
          if (start_rise) state_d = LOAD;
        end
        ERR:     if (start_rise) state_d = LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row         <= '0;
      col         <= '0;
      dwell_q     <= '0;
      wdog_q      <= '0;
      armed_q     <= 1'b0;
      load_params <= 1'b0;
      start_comp  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      row         <= row_d;
      col         <= col_d;
      dwell_q     <= dwell_d;
      wdog_q      <= wdog_d;
      armed_q     <= armed_d;
      load_params <= (state_d == LOAD);
      start_comp  <= (state_d == START);
      busy        <= (state_d == LOAD) || (state_d == START) ||
                     (state_d == WAIT) || (state_d == SCAN);
      done        <= (state_d == DONE);
      err         <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_sys_array_seq.sv
// Directed self-checking bench for sys_array_seq (ROWS=3, COLS=4, DWELL=2,
// TIMEOUT=20).
module tb_sys_array_seq;

  logic       clk = 1'b0;
  logic       reset, start, abort, ready;
  logic [3:0] sel_row, sel_col;
  logic       load_params, start_comp, busy, done, err;
  logic [3:0] row, col;

  int checks = 0;
  int errors = 0;

  sys_array_seq #(
    .ROWS(3), .COLS(4), .ROW_W(4), .COL_W(4), .DWELL(2), .TIMEOUT(20)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ready(ready),
    .sel_row(sel_row), .sel_col(sel_col),
    .load_params(load_params), .start_comp(start_comp),
    .row(row), .col(col), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "bench timeout");
  end

  // Flags are packed as {load_params, start_comp, busy, done, err}.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
    sel_row = '0; sel_col = '0;
    step(); step();
    reset = 1'b0;
    chk("reset_flags", {load_params, start_comp, busy, done, err}, 5'b00000);
    chk("reset_rowcol", {row, col}, 8'h00);

    // Start with ready held high: pulses, then watchdog expiry.
    start = 1'b1;
    step();
    chk("load_pulse", {load_params, start_comp, busy, done, err}, 5'b10100);
    step();
    chk("start_pulse", {load_params, start_comp, busy, done, err}, 5'b01100);
    step();
    chk("wait_entry", {load_params, start_comp, busy, done, err}, 5'b00100);
    start = 1'b0;
    for (int i = 0; i < 19; i++) step();
    chk("wdog_19", {load_params, start_comp, busy, done, err}, 5'b00100);
    step();
    chk("wdog_20_err", {load_params, start_comp, busy, done, err}, 5'b00001);
    step();
    chk("err_hold", {load_params, start_comp, busy, done, err, row, col}, {5'b00001, 8'h00});

    // Rerun from ERR.
    start = 1'b1;
    step();
    chk("rerun_load", {load_params, start_comp, busy, done, err}, 5'b10100);
    step();
    chk("rerun_start", {load_params, start_comp, busy, done, err}, 5'b01100);
    step();
    chk("rerun_wait", {load_params, start_comp, busy, done, err}, 5'b00100);

    // ready 1->0->1: full scan, start toggled mid-scan.
    ready = 1'b0;
    step();
    ready = 1'b1;
    step();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 2; k++) begin
          if (r == 1 && c == 0 && k == 0) start = 1'b0;
          if (r == 1 && c == 1 && k == 0) start = 1'b1;
          if (r == 2 && c == 0 && k == 0) start = 1'b0;
          chk("scan_elem", {24'h0, row, col}, {24'h0, r[3:0], c[3:0]});
          chk("scan_flags", {load_params, start_comp, busy, done, err}, 5'b00100);
          step();
        end
      end
    end
    chk("scan_done", {load_params, start_comp, busy, done, err}, 5'b00010);

    sel_row = 4'd2; sel_col = 4'd1;
    step();
    chk("done_sel", {row, col}, 8'h21);
    sel_row = 4'd9; sel_col = 4'd15;
    step();
    chk("done_sel_oob", {row, col}, 8'h9f);

    // Abort in SCAN at (1,2).
    start = 1'b1;
    step();
    chk("run3_load", {load_params, start_comp, busy, done, err}, 5'b10100);
    step(); step();
    start = 1'b0;
    ready = 1'b0;
    step();
    ready = 1'b1;
    step();
    chk("run3_scan00", {row, col}, 8'h00);
    for (int i = 0; i < 12; i++) step();
    chk("run3_at_12", {row, col}, 8'h12);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_flags", {load_params, start_comp, busy, done, err}, 5'b00000);
    chk("abort_rowcol", {row, col}, 8'h00);
    step();
    chk("abort_stay_idle", {load_params, start_comp, busy, done, err, row, col}, 13'h0);

    // Reset asserted in WAIT.
    start = 1'b1;
    step(); step(); step();
    chk("run4_wait", {load_params, start_comp, busy, done, err}, 5'b00100);
    reset = 1'b1;
    start = 1'b0;
    step();
    chk("reset_wait_flags", {load_params, start_comp, busy, done, err}, 5'b00000);
    chk("reset_wait_rowcol", {row, col}, 8'h00);
    reset = 1'b0;
    step();
    chk("post_reset_idle", {load_params, start_comp, busy, done, err}, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
